// File: rtl/ps2_transmitter_if.sv
// Host-side bundle for the PS/2 transmitter: byte request handshake, status pulses
// and the raw line levels / pull-low enables of the open-drain PS/2 pads.
interface ps2_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clock_in;
    logic       ps2_data_in;
    logic       ps2_clock_oe;
    logic       ps2_data_oe;

    // Master is the command source plus the pad side that returns line levels.
    modport master (
        output tx_data,
        output tx_start,
        output ps2_clock_in,
        output ps2_data_in,
        input  tx_busy,
        input  tx_done,
        input  tx_error,
        input  ps2_clock_oe,
        input  ps2_data_oe
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        input  ps2_clock_in,
        input  ps2_data_in,
        output tx_busy,
        output tx_done,
        output tx_error,
        output ps2_clock_oe,
        output ps2_data_oe
    );
endinterface

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter (inhibit, request, 11 device clocks, ack).
// Optional macro PS2_TX_ACK_CHECK_EN turns a high ack bit into a tx_error abort.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic             clock,
    input  logic             reset,
    ps2_transmitter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [3:0]       PARITY_IDX   = 4'd8;
    localparam logic [3:0]       STOP_IDX     = 4'd9;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] next_counter;
    logic [CNT_W-1:0] counter_inc;
    logic [3:0]       bit_idx;
    logic [3:0]       next_bit_idx;
    logic [9:0]       shift_reg;
    logic [9:0]       next_shift_reg;
    logic             done_pulse;
    logic             next_done_pulse;
    logic             error_pulse;
    logic             next_error_pulse;

    logic             clk_meta;
    logic             clk_sync;
    logic             clk_prev;
    logic             data_meta;
    logic             data_sync;
    logic             fall;
    logic             timed_out;

    // Two-flop synchronisers; reset to the idle (released, high) line level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= bus.ps2_clock_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= bus.ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign fall        = clk_prev & ~clk_sync;
    assign counter_inc = (counter == CNT_MAX) ? counter : counter + CNT_W'(1);
    assign timed_out   = (counter >= TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            done_pulse  <= 1'b0;
            error_pulse <= 1'b0;
        end else begin
            state       <= next_state;
            counter     <= next_counter;
            bit_idx     <= next_bit_idx;
            shift_reg   <= next_shift_reg;
            done_pulse  <= next_done_pulse;
            error_pulse <= next_error_pulse;
        end
    end

    // A device fall is checked before the timeout so a late-but-valid edge still counts.
    always_comb begin
        next_state       = state;
        next_counter     = counter;
        next_bit_idx     = bit_idx;
        next_shift_reg   = shift_reg;
        next_done_pulse  = 1'b0;
        next_error_pulse = 1'b0;

        case (state)
            IDLE: begin
                next_counter = '0;
                next_bit_idx = '0;
                if (bus.tx_start) begin
                    next_shift_reg = {1'b1, ~^bus.tx_data, bus.tx_data};
                    next_state     = INHIBIT;
                end
            end

            INHIBIT: begin
                if (counter >= INHIBIT_LAST) begin
                    next_counter = '0;
                    next_state   = REQ;
                end else begin
                    next_counter = counter_inc;
                end
            end

            REQ: begin
                if (fall) begin
                    next_counter = '0;
                    next_bit_idx = '0;
                    next_state   = DATA;
                end else if (timed_out) begin
                    next_counter     = '0;
                    next_error_pulse = 1'b1;
                    next_state       = IDLE;
                end else begin
                    next_counter = counter_inc;
                end
            end

            DATA: begin
                if (fall) begin
                    next_counter = '0;
                    if (bit_idx == PARITY_IDX) begin
                        next_bit_idx = STOP_IDX;
                        next_state   = ACK;
                    end else begin
                        next_bit_idx = bit_idx + 4'd1;
                    end
                end else if (timed_out) begin
                    next_counter     = '0;
                    next_error_pulse = 1'b1;
                    next_state       = IDLE;
                end else begin
                    next_counter = counter_inc;
                end
            end

            ACK: begin
                if (fall) begin
                    next_counter = '0;
`ifdef PS2_TX_ACK_CHECK_EN
                    if (data_sync) begin
                        next_error_pulse = 1'b1;
                        next_state       = IDLE;
                    end else begin
                        next_state = DONE;
                    end
`else
                    next_state = DONE;
`endif
                end else if (timed_out) begin
                    next_counter     = '0;
                    next_error_pulse = 1'b1;
                    next_state       = IDLE;
                end else begin
                    next_counter = counter_inc;
                end
            end

            DONE: begin
                if (clk_sync && data_sync) begin
                    next_counter    = '0;
                    next_done_pulse = 1'b1;
                    next_state      = IDLE;
                end else if (timed_out) begin
                    next_counter     = '0;
                    next_error_pulse = 1'b1;
                    next_state       = IDLE;
                end else begin
                    next_counter = counter_inc;
                end
            end

            default: begin
                next_counter = '0;
                next_state   = IDLE;
            end
        endcase
    end

    // Start bit in REQ is a pull-low; data bits pull low only for a 0.
    always_comb begin
        bus.ps2_clock_oe = (state == INHIBIT);
        bus.ps2_data_oe  = 1'b0;
        case (state)
            REQ:     bus.ps2_data_oe = 1'b1;
            DATA:    bus.ps2_data_oe = ~shift_reg[bit_idx];
            default: bus.ps2_data_oe = 1'b0;
        endcase
    end

    assign bus.tx_busy  = (state != IDLE);
    assign bus.tx_done  = done_pulse;
    assign bus.tx_error = error_pulse;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Self-checking bench for ps2_transmitter: behavioural PS/2 device on an open-drain
// bus model, table-driven frames, random bytes against a frame model, and corner cases.
module tb_ps2_transmitter;

    localparam int INHIBIT = 40;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 12;
    localparam int SYNC_LAT = 3;

`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         ack_high;
        logic [9:0] exp_bits;
        bit         exp_done;
        bit         exp_error;
    } vec_t;

    logic clock    = 1'b0;
    logic reset    = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    int cyc       = 0;
    int check_cnt = 0;
    int pass_cnt  = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int done_cyc  = 0;
    int err_cyc   = 0;
    int last_req_cyc  = 0;
    int last_fall_cyc = 0;

    ps2_transmitter_if bus ();

    // Open-drain wired-AND of host pull-downs and the device model.
    assign bus.ps2_clock_in = dev_clk & ~bus.ps2_clock_oe;
    assign bus.ps2_data_in  = dev_data & ~bus.ps2_data_oe;

    ps2_transmitter #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Frame on the wire: d0..d7, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones;
        ones = $countones(d);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    always @(negedge clock) begin
        if (reset && (bus.tx_done || bus.tx_error)) begin
            if (bus.tx_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.tx_error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            check_output("pulse_exclusive", {31'b0, bus.tx_done & bus.tx_error}, 32'd0);
            check_output("busy_low_on_pulse", {31'b0, bus.tx_busy}, 32'd0);
        end
    end

    task automatic wait_for_pulse(input int d0, input int e0);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < TIMEOUT + 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= TIMEOUT + 200) check_output("pulse_wait_expired", 32'd1, 32'd0);
        repeat (5) @(negedge clock);
    endtask

    // One host transfer with the device model; stop_after = number of device falls
    // (0 = never clocks, 11 = full frame), optional mid-frame reset and busy start.
    task automatic apply_stimulus(input logic [7:0] data, input int stop_after, input bit ack_high,
                                  input bit spurious, input bit do_reset,
                                  output logic [9:0] bits, output int got_done, output int got_err);
        int  n;
        int  d0;
        int  e0;
        bit  stopped;
        bits    = 10'bx;
        stopped = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clock);
        bus.tx_data  = data;
        bus.tx_start = 1'b1;
        @(negedge clock);
        bus.tx_start = 1'b0;
        check_output("busy_after_start", {31'b0, bus.tx_busy}, 32'd1);
        n = 0;
        while (bus.ps2_clock_oe === 1'b1 && n < INHIBIT + 50) begin
            n++;
            @(negedge clock);
        end
        check_output("inhibit_cycles", n, INHIBIT);
        check_output("req_data_oe", {31'b0, bus.ps2_data_oe}, 32'd1);
        check_output("req_clock_oe", {31'b0, bus.ps2_clock_oe}, 32'd0);
        last_req_cyc = cyc;
        if (stop_after > 0) begin
            repeat (10) @(negedge clock);
            for (int f = 1; f <= stop_after; f++) begin
                dev_clk = 1'b0;
                last_fall_cyc = cyc;
                repeat (HALF) @(negedge clock);
                if (f <= 10) bits[f-1] = bus.ps2_data_in;
                if (do_reset && f == stop_after) begin
                    reset    = 1'b0;
                    dev_clk  = 1'b1;
                    dev_data = 1'b1;
                    @(negedge clock);
                    check_output("rst_clock_oe", {31'b0, bus.ps2_clock_oe}, 32'd0);
                    check_output("rst_data_oe", {31'b0, bus.ps2_data_oe}, 32'd0);
                    check_output("rst_busy", {31'b0, bus.tx_busy}, 32'd0);
                    check_output("rst_done", {31'b0, bus.tx_done}, 32'd0);
                    check_output("rst_error", {31'b0, bus.tx_error}, 32'd0);
                    reset   = 1'b1;
                    stopped = 1'b1;
                    break;
                end
                if (f == stop_after && f < 11) break;
                dev_clk = 1'b1;
                if (f == 10 && !ack_high) dev_data = 1'b0;
                if (spurious && f == 3) begin
                    bus.tx_data  = 8'h00;
                    bus.tx_start = 1'b1;
                    @(negedge clock);
                    bus.tx_start = 1'b0;
                    bus.tx_data  = data;
                    repeat (HALF - 1) @(negedge clock);
                end else begin
                    repeat (HALF) @(negedge clock);
                end
            end
            dev_data = 1'b1;
        end
        if (!stopped) begin
            wait_for_pulse(d0, e0);
            dev_clk = 1'b1;
            repeat (5) @(negedge clock);
        end else begin
            repeat (20) @(negedge clock);
        end
        got_done = done_cnt - d0;
        got_err  = err_cnt - e0;
    endtask

    task automatic check_released(input string tag);
        check_output({tag, "_clock_oe"}, {31'b0, bus.ps2_clock_oe}, 32'd0);
        check_output({tag, "_data_oe"}, {31'b0, bus.ps2_data_oe}, 32'd0);
        check_output({tag, "_busy"}, {31'b0, bus.tx_busy}, 32'd0);
    endtask

    initial begin
        vec_t       vecs[5];
        logic [9:0] bits;
        logic [9:0] exp;
        logic [7:0] rnd;
        int         got_done;
        int         got_err;

        vecs[0] = '{data: 8'hED, ack_high: 1'b0, exp_bits: 10'h3ED, exp_done: 1'b1, exp_error: 1'b0};
        vecs[1] = '{data: 8'h00, ack_high: 1'b0, exp_bits: 10'h300, exp_done: 1'b1, exp_error: 1'b0};
        vecs[2] = '{data: 8'h01, ack_high: 1'b0, exp_bits: 10'h201, exp_done: 1'b1, exp_error: 1'b0};
        vecs[3] = '{data: 8'hFF, ack_high: 1'b0, exp_bits: 10'h3FF, exp_done: 1'b1, exp_error: 1'b0};
        vecs[4] = '{data: 8'h5A, ack_high: 1'b1, exp_bits: 10'h35A, exp_done: !ACK_CHECK, exp_error: ACK_CHECK};

        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        reset        = 1'b0;
        repeat (3) @(negedge clock);
        check_output("reset_clock_oe", {31'b0, bus.ps2_clock_oe}, 32'd0);
        check_output("reset_data_oe", {31'b0, bus.ps2_data_oe}, 32'd0);
        check_output("reset_busy", {31'b0, bus.tx_busy}, 32'd0);
        check_output("reset_done", {31'b0, bus.tx_done}, 32'd0);
        check_output("reset_error", {31'b0, bus.tx_error}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].data, 11, vecs[i].ack_high, 1'b0, 1'b0, bits, got_done, got_err);
            check_output("vec_frame", {22'b0, bits}, {22'b0, vecs[i].exp_bits});
            check_output("vec_parity", {31'b0, bits[8]}, {31'b0, vecs[i].exp_bits[8]});
            check_output("vec_done", got_done, {31'b0, vecs[i].exp_done});
            check_output("vec_error", got_err, {31'b0, vecs[i].exp_error});
            check_released("vec_end");
        end

        for (int i = 0; i < 6; i++) begin
            rnd = 8'($urandom_range(0, 255));
            exp = model_frame(rnd);
            apply_stimulus(rnd, 11, 1'b0, 1'b0, 1'b0, bits, got_done, got_err);
            check_output("rand_frame", {22'b0, bits}, {22'b0, exp});
            check_output("rand_done", got_done, 32'd1);
            check_output("rand_error", got_err, 32'd0);
        end

        // Device never answers the request.
        apply_stimulus(8'h12, 0, 1'b0, 1'b0, 1'b0, bits, got_done, got_err);
        check_output("noclk_delay", err_cyc - last_req_cyc, TIMEOUT);
        check_output("noclk_error", got_err, 32'd1);
        check_output("noclk_done", got_done, 32'd0);
        check_released("noclk");

        // Device stalls with its clock low after the fourth fall.
        apply_stimulus(8'hA5, 4, 1'b0, 1'b0, 1'b0, bits, got_done, got_err);
        check_output("stall_delay", err_cyc - last_fall_cyc, TIMEOUT + SYNC_LAT);
        check_output("stall_error", got_err, 32'd1);
        check_output("stall_done", got_done, 32'd0);
        check_output("stall_bits", {28'b0, bits[3:0]}, 32'h5);
        check_released("stall");

        // Reset mid-DATA, then a clean 0xFF with a start pulse while busy.
        apply_stimulus(8'h3C, 5, 1'b0, 1'b0, 1'b1, bits, got_done, got_err);
        check_output("midreset_done", got_done, 32'd0);
        check_output("midreset_error", got_err, 32'd0);
        apply_stimulus(8'hFF, 11, 1'b0, 1'b1, 1'b0, bits, got_done, got_err);
        check_output("after_reset_frame", {22'b0, bits}, {22'b0, model_frame(8'hFF)});
        check_output("after_reset_done", got_done, 32'd1);
        check_output("after_reset_error", got_err, 32'd0);
        check_released("after_reset");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, check_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
